// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt scheduler.
//   irq_state_t      : request/acknowledge/end-of-interrupt FSM states
//   NUM_IRQ_DEF      : default number of interrupt sources
//   ACK_TIMEOUT_DEF  : default cycles irq_req may wait for irq_ack
package irq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        SERVICE
    } irq_state_t;

    localparam int NUM_IRQ_DEF     = 8;
    localparam int ACK_TIMEOUT_DEF = 16;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder, highest set index wins (same ordering as the
// status-flag priority encoder).
//   req   : request vector
//   vec   : index of the highest set bit of req (0 when none set)
//   valid : at least one bit of req is set
module irq_prio_enc #(
    parameter int N = 8,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    output logic [W-1:0] vec,
    output logic         valid
);

    always_comb begin
        vec   = '0;
        valid = |req;
        // Ascending scan: the last hit, i.e. the highest index, is kept.
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                vec = i[W-1:0];
            end
        end
    end

endmodule

// File: rtl/irq_sched.sv
// Interrupt scheduler: edge-latches eight source lines into pending,
// masks them, picks the highest eligible index and runs the
// request / acknowledge / end-of-interrupt handshake with the core,
// gated by the global interrupt enable (status bit 7).
//   clk, rstN   : clock, synchronous active-low reset
//   irq_lines   : level request lines from the sources
//   int_en      : global interrupt enable
//   mask_wr     : mask register write strobe, mask_wdata new value (1=masked)
//   irq_ack     : core accepts irq_vec (honoured in REQ only)
//   eoi         : end of interrupt (honoured in SERVICE only)
//   irq_req     : registered request to the core
//   irq_vec     : registered index of the requested / serviced source
//   mask        : current mask register
//   pending     : latched, unserviced requests
//   in_service  : one-hot source being serviced, or 0
//   busy        : FSM not in IDLE
//   timeout_err : one-cycle pulse when a request is abandoned unacknowledged
module irq_sched
    import irq_pkg::*;
#(
    parameter int NUM_IRQ     = NUM_IRQ_DEF,
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF,
    parameter int VW          = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic               clk,
    input  logic               rstN,
    input  logic [NUM_IRQ-1:0] irq_lines,
    input  logic               int_en,
    input  logic               mask_wr,
    input  logic [NUM_IRQ-1:0] mask_wdata,
    input  logic               irq_ack,
    input  logic               eoi,
    output logic               irq_req,
    output logic [VW-1:0]      irq_vec,
    output logic [NUM_IRQ-1:0] mask,
    output logic [NUM_IRQ-1:0] pending,
    output logic [NUM_IRQ-1:0] in_service,
    output logic               busy,
    output logic               timeout_err
);

    localparam int CW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [NUM_IRQ-1:0] ONE = {{(NUM_IRQ-1){1'b0}}, 1'b1};

    irq_state_t         state_q, state_d;
    logic [NUM_IRQ-1:0] prev_q, prev_d;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] mask_q, mask_d;
    logic [NUM_IRQ-1:0] in_service_q, in_service_d;
    logic               req_q, req_d;
    logic [VW-1:0]      vec_q, vec_d;
    logic               tout_q, tout_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] eligible;
    logic [NUM_IRQ-1:0] ack_clr;
    logic [VW-1:0]      win_vec;
    logic               win_valid;

    assign rise     = irq_lines & ~prev_q;
    assign eligible = pending_q & ~mask_q;

    irq_prio_enc #(
        .N (NUM_IRQ),
        .W (VW)
    ) u_prio_enc (
        .req   (eligible),
        .vec   (win_vec),
        .valid (win_valid)
    );

    always_comb begin
        state_d      = state_q;
        prev_d       = irq_lines;
        mask_d       = mask_wr ? mask_wdata : mask_q;
        in_service_d = in_service_q;
        req_d        = req_q;
        vec_d        = vec_q;
        tout_d       = 1'b0;
        cnt_d        = cnt_q;
        ack_clr      = '0;

        unique case (state_q)
            IDLE: begin
                req_d = 1'b0;
                if (int_en && win_valid) begin
                    state_d = REQ;
                    req_d   = 1'b1;
                    vec_d   = win_vec;
                    cnt_d   = '0;
                end
            end
            REQ: begin
                // The ack refers to the vector the core currently sees (vec_q);
                // it takes precedence over withdrawal and timeout.
                if (irq_ack) begin
                    state_d      = SERVICE;
                    req_d        = 1'b0;
                    ack_clr      = ONE << vec_q;
                    in_service_d = ONE << vec_q;
                end else if (!int_en || !win_valid) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                end else if (cnt_q == CW'(ACK_TIMEOUT - 1)) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                    tout_d  = 1'b1;
                end else begin
                    // Track the current winner so a higher source pre-empts.
                    vec_d = win_vec;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SERVICE: begin
                req_d = 1'b0;
                if (eoi) begin
                    state_d      = IDLE;
                    in_service_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase

        // A new edge on the bit being acknowledged wins over the clear.
        pending_d = (pending_q & ~ack_clr) | rise;
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            state_q      <= IDLE;
            prev_q       <= '1;
            pending_q    <= '0;
            mask_q       <= '1;
            in_service_q <= '0;
            req_q        <= 1'b0;
            vec_q        <= '0;
            tout_q       <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            pending_q    <= pending_d;
            mask_q       <= mask_d;
            in_service_q <= in_service_d;
            req_q        <= req_d;
            vec_q        <= vec_d;
            tout_q       <= tout_d;
            cnt_q        <= cnt_d;
        end
    end

    assign irq_req     = req_q;
    assign irq_vec     = vec_q;
    assign mask        = mask_q;
    assign pending     = pending_q;
    assign in_service  = in_service_q;
    assign busy        = (state_q != IDLE);
    assign timeout_err = tout_q;

endmodule

// File: tb/tb_irq_sched.sv
// Directed bench for irq_sched. Expected vectors are queued when the
// stimulus that should cause them is driven and popped when irq_req shows.
module tb_irq_sched;

    logic       clk = 1'b0;
    logic       rstN;
    logic [7:0] irq_lines;
    logic       int_en;
    logic       mask_wr;
    logic [7:0] mask_wdata;
    logic       irq_ack;
    logic       eoi;
    logic       irq_req;
    logic [2:0] irq_vec;
    logic [7:0] mask;
    logic [7:0] pending;
    logic [7:0] in_service;
    logic       busy;
    logic       timeout_err;

    int total = 0;
    int bad   = 0;
    int exp_q[$];

    irq_sched dut (
        .clk         (clk),
        .rstN        (rstN),
        .irq_lines   (irq_lines),
        .int_en      (int_en),
        .mask_wr     (mask_wr),
        .mask_wdata  (mask_wdata),
        .irq_ack     (irq_ack),
        .eoi         (eoi),
        .irq_req     (irq_req),
        .irq_vec     (irq_vec),
        .mask        (mask),
        .pending     (pending),
        .in_service  (in_service),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for irq_req, then compare irq_vec with the scoreboard head.
    task automatic expect_req(input string tag);
        int n;
        int ev;
        n = 0;
        while (irq_req !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk({tag, "_req"}, {31'd0, irq_req}, 32'd1);
        ev = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        chk({tag, "_vec"}, {29'd0, irq_vec}, ev);
        $display("req %s: vec=%0d expected=%0d after %0d cycles", tag, irq_vec, ev, n);
    endtask

    task automatic do_ack();
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
    endtask

    task automatic do_eoi();
        eoi = 1'b1;
        step();
        eoi = 1'b0;
    endtask

    task automatic write_mask(input logic [7:0] m);
        mask_wr    = 1'b1;
        mask_wdata = m;
        step();
        mask_wr    = 1'b0;
    endtask

    initial begin
        rstN       = 1'b0;
        irq_lines  = '0;
        int_en     = 1'b0;
        mask_wr    = 1'b0;
        mask_wdata = '0;
        irq_ack    = 1'b0;
        eoi        = 1'b0;
        step();
        step();
        chk("rst_req",   {31'd0, irq_req}, 32'd0);
        chk("rst_vec",   {29'd0, irq_vec}, 32'd0);
        chk("rst_mask",  {24'd0, mask}, 32'hFF);
        chk("rst_pend",  {24'd0, pending}, 32'd0);
        chk("rst_insvc", {24'd0, in_service}, 32'd0);
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        chk("rst_tout",  {31'd0, timeout_err}, 32'd0);
        rstN = 1'b1;
        write_mask(8'h00);
        chk("mask_wr0", {24'd0, mask}, 32'h00);
        int_en = 1'b1;

        // Single source, exact latency: pending after rise edge, req one edge later.
        irq_lines = 8'h08;
        exp_q.push_back(3);
        step();
        chk("t1_pend",   {24'd0, pending}, 32'h08);
        chk("t1_noreq",  {31'd0, irq_req}, 32'd0);
        step();
        expect_req("t1");
        irq_lines = 8'h00;
        do_ack();
        chk("t1_insvc",  {24'd0, in_service}, 32'h08);
        chk("t1_pclr",   {24'd0, pending}, 32'h00);
        chk("t1_sreq",   {31'd0, irq_req}, 32'd0);
        chk("t1_svec",   {29'd0, irq_vec}, 32'd3);
        chk("t1_busy",   {31'd0, busy}, 32'd1);
        do_eoi();
        chk("t1_idle",   {31'd0, busy}, 32'd0);
        chk("t1_isclr",  {24'd0, in_service}, 32'h00);

        // Two sources at once: 5 first, then 2 without new stimulus.
        irq_lines = 8'h24;
        exp_q.push_back(5);
        exp_q.push_back(2);
        step();
        step();
        expect_req("t2a");
        irq_lines = 8'h00;
        do_ack();
        chk("t2_pend",   {24'd0, pending}, 32'h04);
        chk("t2_insvc",  {24'd0, in_service}, 32'h20);
        do_eoi();
        expect_req("t2b");
        do_ack();
        do_eoi();

        // Pre-emption of an unacknowledged lower request.
        irq_lines = 8'h02;
        exp_q.push_back(1);
        step();
        step();
        expect_req("t3a");
        irq_lines = 8'h42;
        exp_q.push_back(6);
        step();
        chk("t3_oldvec", {29'd0, irq_vec}, 32'd1);
        step();
        expect_req("t3b");
        do_ack();
        chk("t3_pend",   {24'd0, pending}, 32'h02);
        chk("t3_insvc",  {24'd0, in_service}, 32'h40);
        irq_lines = 8'h00;
        exp_q.push_back(1);
        do_eoi();
        expect_req("t3c");
        do_ack();
        do_eoi();

        // Masked source latches but does not request until unmasked.
        write_mask(8'hFF);
        irq_lines = 8'h10;
        step();
        chk("t4_pend",   {24'd0, pending}, 32'h10);
        step();
        chk("t4_noreq",  {31'd0, irq_req}, 32'd0);
        chk("t4_nobusy", {31'd0, busy}, 32'd0);
        exp_q.push_back(4);
        write_mask(8'h00);
        chk("t4_lag",    {31'd0, irq_req}, 32'd0);
        step();
        expect_req("t4a");
        int_en = 1'b0;
        step();
        chk("t4_ien_req",  {31'd0, irq_req}, 32'd0);
        chk("t4_ien_pend", {24'd0, pending}, 32'h10);
        chk("t4_ien_busy", {31'd0, busy}, 32'd0);
        int_en = 1'b1;
        exp_q.push_back(4);
        step();
        expect_req("t4b");

        // Ack timeout: request held 16 cycles, pulse, then re-request.
        for (int i = 0; i < 15; i++) step();
        chk("t5_still",  {31'd0, irq_req}, 32'd1);
        chk("t5_notout", {31'd0, timeout_err}, 32'd0);
        step();
        chk("t5_tout",   {31'd0, timeout_err}, 32'd1);
        chk("t5_dropreq", {31'd0, irq_req}, 32'd0);
        chk("t5_idle",   {31'd0, busy}, 32'd0);
        chk("t5_pkeep",  {24'd0, pending}, 32'h10);
        exp_q.push_back(4);
        step();
        chk("t5_pulse1", {31'd0, timeout_err}, 32'd0);
        expect_req("t5");
        do_ack();
        do_eoi();
        irq_lines = 8'h00;

        // Line held high through reset produces no edge.
        irq_lines = 8'h80;
        rstN = 1'b0;
        step();
        step();
        rstN = 1'b1;
        step();
        step();
        chk("t6_nopend", {24'd0, pending}, 32'h00);
        irq_lines = 8'h00;

        // Reset during SERVICE returns everything to reset values.
        write_mask(8'h00);
        irq_lines = 8'h01;
        exp_q.push_back(0);
        step();
        step();
        expect_req("t7");
        do_ack();
        chk("t7_svc",    {24'd0, in_service}, 32'h01);
        rstN = 1'b0;
        step();
        rstN = 1'b1;
        chk("t7_req",    {31'd0, irq_req}, 32'd0);
        chk("t7_mask",   {24'd0, mask}, 32'hFF);
        chk("t7_insvc",  {24'd0, in_service}, 32'h00);
        chk("t7_pend",   {24'd0, pending}, 32'h00);
        chk("t7_busy",   {31'd0, busy}, 32'd0);
        chk("t7_vec",    {29'd0, irq_vec}, 32'd0);
        chk("sb_drained", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
